// File: rtl/regfile_write_scheduler_if.sv
// Register-file write scheduler bundle: writeback, long-latency unit,
// clear sequencer control and the register-file write port.
interface regfile_write_scheduler_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_rd;
    logic [DATA_W-1:0] lu_data;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              stall_req;
    logic              RegWrite;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] WriteData;

    modport slave (
        input  wb_we, wb_rd, wb_data,
        input  lu_valid, lu_rd, lu_data,
        input  clr_start,
        output lu_ready, clr_busy, clr_done,
        output stall_req,
        output RegWrite, RD, WriteData
    );

    modport master (
        output wb_we, wb_rd, wb_data,
        output lu_valid, lu_rd, lu_data,
        output clr_start,
        input  lu_ready, clr_busy, clr_done,
        input  stall_req,
        input  RegWrite, RD, WriteData
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between writeback,
// the long-latency unit and a zeroing sweep of x1..x31.
module regfile_write_scheduler #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 8
) (
    input logic                     clk,
    input logic                     reset,
    regfile_write_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              we_q, we_d;
    logic              stall_q, stall_d;
    logic [7:0]        cnt_q, cnt_d;

    logic wb_req;
    logic lu_hs;
    logic lu_refused;
    logic sw_gnt;

    assign wb_req     = bus.wb_we & (bus.wb_rd != '0);
    assign bus.lu_ready = reset & ~wb_req;
    assign lu_hs      = bus.lu_valid & bus.lu_ready;
    assign lu_refused = bus.lu_valid & ~bus.lu_ready;
    assign sw_gnt     = (state_q == SWEEP) & ~wb_req
                      & ~bus.lu_valid;

    // An lu result aimed at x0 is consumed but never written.
    always_comb begin
        we_d = 1'b0;
        rd_d = rd_q;
        wd_d = wd_q;
        unique case (1'b1)
            wb_req: begin
                we_d = 1'b1;
                rd_d = bus.wb_rd;
                wd_d = bus.wb_data;
            end
            lu_hs: begin
                if (bus.lu_rd != '0) begin
                    we_d = 1'b1;
                    rd_d = bus.lu_rd;
                    wd_d = bus.lu_data;
                end
            end
            sw_gnt: begin
                we_d = 1'b1;
                rd_d = idx_q;
                wd_d = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d = SWEEP;
                    idx_d   = FIRST;
                end
            end
            SWEEP: begin
                if (sw_gnt) begin
                    if (idx_q == LAST) state_d = DONE;
                    else idx_d = idx_q + FIRST;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = FIRST;
            end
            default: begin
                state_d = IDLE;
                idx_d   = FIRST;
            end
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (lu_refused)
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 8'd1;
        stall_d = (cnt_q == LIMIT) & lu_refused;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= FIRST;
            we_q    <= 1'b0;
            rd_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.RegWrite  = we_q;
    assign bus.RD        = rd_q;
    assign bus.WriteData = wd_q;
    assign bus.stall_req = stall_q;
    assign bus.clr_busy  = (state_q == SWEEP);
    assign bus.clr_done  = (state_q == DONE);
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench: stimulus queues expected writes, a negedge
// monitor pops them and models the register file.
module tb_regfile_write_scheduler;
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] d;
    } wr_t;

    logic clk;
    logic reset;
    int   cmp_cnt;
    int   err_cnt;
    wr_t  exp_q[$];
    logic [63:0] rf[32];

    regfile_write_scheduler_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    regfile_write_scheduler #(
        .DATA_W(64),
        .ADDR_W(5),
        .STARVE_LIMIT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] pat(int i);
        return 64'h1111_0000_0000_0000 | 64'(i);
    endfunction

    task automatic chk(string nm, logic [127:0] act,
                       logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(int rd, logic [63:0] d);
        wr_t e;
        e.rd = 5'(rd);
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.wb_we     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.lu_valid  = 1'b0;
        bus.lu_rd     = '0;
        bus.lu_data   = '0;
        bus.clr_start = 1'b0;
    endtask

    task automatic fill();
        for (int i = 1; i < 32; i++) begin
            bus.wb_we   = 1'b1;
            bus.wb_rd   = 5'(i);
            bus.wb_data = pat(i);
            push(i, pat(i));
            tick();
        end
        idle();
        tick();
    endtask

    // Monitor: every issued write must match the head of the queue.
    initial begin
        wr_t e;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[0] = 64'hDEAD;
        forever begin
            @(negedge clk);
            if (bus.RegWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_write: rd %0d data %0h want none",
                             bus.RD, bus.WriteData);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", {59'd0, bus.RD, bus.WriteData},
                        {59'd0, e.rd, e.d});
                end
                rf[bus.RD] = bus.WriteData;
            end
        end
    end

    initial begin
        int busy, done, bad;
        cmp_cnt = 0;
        err_cnt = 0;

        reset         = 1'b0;
        bus.wb_we     = 1'b1;
        bus.wb_rd     = 5'd4;
        bus.wb_data   = 64'h44;
        bus.lu_valid  = 1'b1;
        bus.lu_rd     = 5'd6;
        bus.lu_data   = 64'h66;
        bus.clr_start = 1'b1;
        tick(2);
        chk("rst_regwrite", 128'(bus.RegWrite), 0);
        chk("rst_rd", 128'(bus.RD), 0);
        chk("rst_lu_ready", 128'(bus.lu_ready), 0);
        chk("rst_clr_busy", 128'(bus.clr_busy), 0);
        chk("rst_clr_done", 128'(bus.clr_done), 0);
        chk("rst_stall", 128'(bus.stall_req), 0);

        reset         = 1'b1;
        bus.lu_valid  = 1'b0;
        bus.clr_start = 1'b0;
        push(4, 64'h44);
        tick();
        chk("first_grant", {bus.RegWrite, bus.RD, bus.WriteData},
            {1'b1, 5'd4, 64'h44});
        idle();
        tick();

        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 64'hAA;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd5;
        bus.lu_data  = 64'hBB;
        #1;
        chk("same_rd_lu_ready", 128'(bus.lu_ready), 0);
        push(5, 64'hAA);
        tick();
        bus.wb_we = 1'b0;
        #1;
        chk("lu_ready_free", 128'(bus.lu_ready), 1);
        push(5, 64'hBB);
        tick();
        idle();
        tick();
        chk("x5_final", 128'(rf[5]), 128'(64'hBB));

        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 64'h77;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd3;
        bus.lu_data  = 64'h33;
        #1;
        chk("wb_x0_lu_ready", 128'(bus.lu_ready), 1);
        push(3, 64'h33);
        tick();
        bus.wb_we   = 1'b0;
        bus.lu_rd   = 5'd0;
        bus.lu_data = 64'h99;
        #1;
        chk("lu_x0_ready", 128'(bus.lu_ready), 1);
        tick();
        chk("lu_x0_nowrite", {bus.RegWrite, bus.RD},
            {1'b0, 5'd3});
        idle();
        tick();

        fill();
        bus.clr_start = 1'b1;
        for (int i = 1; i < 32; i++) push(i, 64'd0);
        tick();
        bus.clr_start = 1'b0;
        busy = 0;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.clr_busy) busy++;
            if (bus.clr_done) done++;
            tick();
        end
        chk("sweep_busy_cycles", 128'(busy), 31);
        chk("sweep_done_pulses", 128'(done), 1);
        bad = 0;
        for (int i = 1; i < 32; i++)
            if (rf[i] != 64'd0) bad++;
        chk("sweep_cleared", 128'(bad), 0);
        chk("x0_untouched", 128'(rf[0]), 128'(64'hDEAD));

        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd7;
        bus.wb_data  = 64'h77;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd9;
        bus.lu_data  = 64'h99;
        for (int k = 1; k <= 10; k++) begin
            push(7, 64'h77);
            tick();
            chk($sformatf("stall_c%0d", k),
                128'(bus.stall_req), 128'(k >= 9));
        end
        bus.wb_we = 1'b0;
        push(9, 64'h99);
        tick();
        chk("stall_drop", 128'(bus.stall_req), 0);
        bus.wb_we = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push(7, 64'h77);
            tick();
        end
        chk("starve_restart", 128'(bus.stall_req), 0);
        idle();
        tick();

        fill();
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(i, 64'd0);
            tick();
        end
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd20;
        bus.wb_data = 64'h2020;
        push(20, 64'h2020);
        tick();
        bus.wb_we = 1'b0;
        for (int i = 5; i <= 11; i++) begin
            push(i, 64'd0);
            tick();
        end
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd2;
        bus.wb_data = 64'h2222;
        push(2, 64'h2222);
        tick();
        bus.wb_we = 1'b0;
        reset     = 1'b0;
        tick();
        chk("midrst_busy", 128'(bus.clr_busy), 0);
        chk("midrst_done", 128'(bus.clr_done), 0);
        chk("midrst_regwrite", 128'(bus.RegWrite), 0);
        reset = 1'b1;
        done  = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.clr_done || bus.clr_busy) done++;
            tick();
        end
        chk("post_rst_quiet", 128'(done), 0);
        bad = 0;
        for (int i = 1; i < 12; i++)
            if (i != 2 && rf[i] != 64'd0) bad++;
        chk("partial_low", 128'(bad), 0);
        chk("x2_wb", 128'(rf[2]), 128'(64'h2222));
        bad = 0;
        for (int i = 12; i < 32; i++)
            if (rf[i] != ((i == 20) ? 64'h2020 : pat(i))) bad++;
        chk("partial_high", 128'(bad), 0);

        chk("sb_drain", 128'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, err_cnt);
        $finish;
    end
endmodule
